// File: rtl/lfs_pkg.sv
// Shared types and constants for the LFSR / counter display block.
package lfs_pkg;

    typedef enum logic {COUNT = 1'b0, LFSR = 1'b1} mode_e;

    localparam logic [15:0] DEFAULT_TAPS_16 = 16'hB400;

    // Active-low {a,b,c,d,e,f,g,dp}, indexed by nibble value.
    localparam logic [7:0] SEG_HEX [0:15] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
        8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
    };

endpackage

// File: rtl/seg_scan.sv
// Multiplexed hex display driver: cycles one digit at a time, dwell of 2^SCAN_BITS clocks.
module seg_scan
    import lfs_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned SCAN_BITS = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned IDX_BITS = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DIGITS - 1);

    logic [SCAN_BITS-1:0] dwell;
    logic [IDX_BITS-1:0]  idx;
    logic [3:0]           nibble;

    assign nibble = value[4*idx +: 4];

    // seg and an come from the same idx in the same register stage, so they always agree.
    always_ff @(posedge clock) begin
        if (reset) begin
            dwell <= '0;
            idx   <= '0;
            an    <= ~DIGITS'(1);
            seg   <= SEG_HEX[0];
        end else begin
            dwell <= dwell + SCAN_BITS'(1);
            if (&dwell) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_BITS'(1);
            end
            an  <= ~(DIGITS'(1) << idx);
            seg <= SEG_HEX[nibble];
        end
    end

endmodule

// File: rtl/lfs_scan_counter.sv
// Register that either counts or runs as a Fibonacci LFSR on prescaler ticks, shown on a hex display.
module lfs_scan_counter
    import lfs_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(DEFAULT_TAPS_16),
    parameter int unsigned      DIV_BITS  = 24,
    parameter int unsigned      SCAN_BITS = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  toggle,
    input  logic                  load,
    input  logic [WIDTH-1:0]      seed,
    output logic [WIDTH-1:0]      value,
    output logic                  tick,
    output logic [7:0]            seg,
    output logic [WIDTH/4-1:0]    an,
    output logic                  led_cnt,
    output logic                  led_lfsr
);

    localparam int unsigned DIGITS = WIDTH / 4;

    logic [DIV_BITS-1:0] presc;
    logic                toggle_prev;
    mode_e               mode;
    logic                fb;
    logic [WIDTH-1:0]    lfsr_next;
    logic [WIDTH-1:0]    value_next;

    assign tick = &presc;
    assign fb   = ^(value & TAPS);

    always_comb begin
        // All-zero is the LFSR lock-up state; escape it to 1.
        lfsr_next  = (value == '0) ? WIDTH'(1) : {value[WIDTH-2:0], fb};
        value_next = value;
        if (tick) begin
            if (load) begin
                value_next = seed;
            end else if (step) begin
                value_next = (mode == COUNT) ? value + WIDTH'(1) : lfsr_next;
            end
        end
    end

    // value_next reads the pre-flip mode, so a coincident toggle takes effect on the next tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc       <= '0;
            toggle_prev <= 1'b0;
            mode        <= COUNT;
            value       <= '0;
            led_cnt     <= 1'b1;
            led_lfsr    <= 1'b0;
        end else begin
            presc       <= presc + DIV_BITS'(1);
            toggle_prev <= toggle;
            if (toggle && !toggle_prev) begin
                mode <= (mode == COUNT) ? LFSR : COUNT;
            end
            value       <= value_next;
            led_cnt     <= (mode == COUNT);
            led_lfsr    <= (mode == LFSR);
        end
    end

    seg_scan #(
        .DIGITS    (DIGITS),
        .SCAN_BITS (SCAN_BITS)
    ) u_seg_scan (
        .clock (clock),
        .reset (reset),
        .value (value),
        .seg   (seg),
        .an    (an)
    );

endmodule

// File: tb/tb_lfs_scan_counter.sv
// Bench for lfs_scan_counter: 16-bit main instance, 8-bit LFSR period instance, 32-bit display instance.
module tb_lfs_scan_counter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // 16-bit instance
    logic        step16 = 0, toggle16 = 0, load16 = 0;
    logic [15:0] seed16 = '0;
    logic [15:0] value16;
    logic        tick16, led_cnt16, led_lfsr16;
    logic [7:0]  seg16;
    logic [3:0]  an16;

    // 8-bit instance for a full LFSR period
    logic        step8 = 0, toggle8 = 0, load8 = 0;
    logic [7:0]  seed8 = '0;
    logic [7:0]  value8;
    logic        tick8, led_cnt8, led_lfsr8;
    logic [7:0]  seg8;
    logic [1:0]  an8;

    // 32-bit instance for the 8-digit scan
    logic        step32 = 0, toggle32 = 0, load32 = 0;
    logic [31:0] seed32 = '0;
    logic [31:0] value32;
    logic        tick32, led_cnt32, led_lfsr32;
    logic [7:0]  seg32;
    logic [7:0]  an32;

    lfs_scan_counter #(.WIDTH(16), .DIV_BITS(2), .SCAN_BITS(1)) dut16 (
        .clock(clock), .reset(reset), .step(step16), .toggle(toggle16), .load(load16),
        .seed(seed16), .value(value16), .tick(tick16), .seg(seg16), .an(an16),
        .led_cnt(led_cnt16), .led_lfsr(led_lfsr16)
    );

    lfs_scan_counter #(.WIDTH(8), .TAPS(8'hB8), .DIV_BITS(1), .SCAN_BITS(1)) dut8 (
        .clock(clock), .reset(reset), .step(step8), .toggle(toggle8), .load(load8),
        .seed(seed8), .value(value8), .tick(tick8), .seg(seg8), .an(an8),
        .led_cnt(led_cnt8), .led_lfsr(led_lfsr8)
    );

    lfs_scan_counter #(.WIDTH(32), .DIV_BITS(2), .SCAN_BITS(1)) dut32 (
        .clock(clock), .reset(reset), .step(step32), .toggle(toggle32), .load(load32),
        .seed(seed32), .value(value32), .tick(tick32), .seg(seg32), .an(an32),
        .led_cnt(led_cnt32), .led_lfsr(led_lfsr32)
    );

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: got timeout, want event", name);
    endtask

    // Monitor: each tick edge of the 16-bit instance is a value update; compare against the queue.
    always @(posedge clock) begin
        if (tick16 && !reset && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            #1;
            check(e.name, 32'(value16), 32'(e.val));
        end
    end

    function automatic logic [15:0] lfsr16(input logic [15:0] v);
        if (v == 16'h0) return 16'h0001;
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic wait_tick16(input string name);
        bit seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clock);
            if (tick16) seen = 1;
        end
        if (!seen) timeout_fail(name);
    endtask

    // Drives load/step for exactly one tick and queues the expected value.
    task automatic apply_tick(input string name, input logic ld, input logic st,
                              input logic [15:0] sd, input logic [15:0] want);
        exp_t e;
        wait_tick16(name);
        load16 = ld;
        step16 = st;
        seed16 = sd;
        e.name = name;
        e.val  = want;
        exp_q.push_back(e);
        @(negedge clock);
        load16 = 0;
        step16 = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) timeout_fail("queue_drain");
    endtask

    task automatic pulse_toggle16();
        @(negedge clock);
        toggle16 = 1;
        @(negedge clock);
        toggle16 = 0;
        @(negedge clock);
    endtask

    task automatic wait_an16(input string name, input logic [3:0] want, input bit equal);
        bit seen = 0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clock);
            if ((an16 == want) == equal) seen = 1;
        end
        if (!seen) timeout_fail(name);
    endtask

    task automatic wait_tick8();
        bit seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clock);
            if (tick8) seen = 1;
        end
        if (!seen) timeout_fail("tick8");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prev_an;
        int         steps;
        bit         found;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_value", 32'(value16), 32'h0);
        check("rst_tick", 32'(tick16), 32'h0);
        check("rst_led_cnt", 32'(led_cnt16), 32'h1);
        check("rst_led_lfsr", 32'(led_lfsr16), 32'h0);
        check("rst_an", 32'(an16), 32'h0000_000E);
        check("rst_seg", 32'(seg16), 32'h0000_0003);
        reset = 0;

        // 32-bit scan: walk through all 8 digit selects and back to digit 0
        begin
            bit seen = 0;
            for (int i = 0; i < 32 && !seen; i++) begin
                @(negedge clock);
                if (an32 == 8'hFE) seen = 1;
            end
            if (!seen) timeout_fail("an32_start");
            for (int k = 1; k <= 8; k++) begin
                logic [7:0] want_an;
                want_an = ~(8'd1 << (k % 8));
                prev_an = an32;
                seen = 0;
                for (int i = 0; i < 8 && !seen; i++) begin
                    @(negedge clock);
                    if (an32 != prev_an) seen = 1;
                end
                if (!seen) timeout_fail("an32_advance");
                check("an32_digit", 32'(an32), 32'(want_an));
            end
            check("seg32_zero", 32'(seg32), 32'h0000_0003);
        end

        // Count wrap
        apply_tick("load_fffe", 1, 0, 16'hFFFE, 16'hFFFE);
        apply_tick("count_ffff", 0, 1, 16'h0, 16'hFFFF);
        apply_tick("count_wrap", 0, 1, 16'h0, 16'h0000);
        drain();
        check("wrap_led_cnt", 32'(led_cnt16), 32'h1);

        // LFSR step from ACE1
        apply_tick("load_ace1", 1, 0, 16'hACE1, 16'hACE1);
        drain();
        pulse_toggle16();
        check("lfsr_led_lfsr", 32'(led_lfsr16), 32'h1);
        check("lfsr_led_cnt", 32'(led_cnt16), 32'h0);
        check("toggle_keeps_ace1", 32'(value16), 32'h0000_ACE1);
        apply_tick("lfsr_59c3", 0, 1, 16'h0, 16'h59C3);
        drain();
        pulse_toggle16();
        repeat (10) @(negedge clock);
        check("toggle_keeps_59c3", 32'(value16), 32'h0000_59C3);
        check("back_count_led", 32'(led_cnt16), 32'h1);
        pulse_toggle16();
        check("relfsr_led", 32'(led_lfsr16), 32'h1);

        // Reset mid-run overrides load/step/toggle
        load16 = 1; step16 = 1; toggle16 = 1; seed16 = 16'h5555; reset = 1;
        @(negedge clock);
        check("mid_rst_value", 32'(value16), 32'h0);
        check("mid_rst_tick", 32'(tick16), 32'h0);
        check("mid_rst_led_cnt", 32'(led_cnt16), 32'h1);
        check("mid_rst_led_lfsr", 32'(led_lfsr16), 32'h0);
        check("mid_rst_an", 32'(an16), 32'h0000_000E);
        check("mid_rst_seg", 32'(seg16), 32'h0000_0003);
        load16 = 0; step16 = 0; toggle16 = 0; reset = 0;

        // Lock-up escape and a few LFSR steps
        pulse_toggle16();
        check("lockup_mode", 32'(led_lfsr16), 32'h1);
        begin
            logic [15:0] v;
            v = lfsr16(16'h0);
            apply_tick("lockup_0001", 0, 1, 16'h0, v);
            for (int i = 0; i < 5; i++) begin
                v = lfsr16(v);
                apply_tick("lfsr_walk", 0, 1, 16'h0, v);
            end
        end
        drain();

        // Priority: load beats step
        pulse_toggle16();
        apply_tick("load_over_step", 1, 1, 16'h1234, 16'h1234);
        drain();

        // Display of 1234
        repeat (2) @(negedge clock);
        wait_an16("an16_digit0", 4'b1110, 1);
        check("seg_digit0", 32'(seg16), 32'h0000_0099);
        wait_an16("an16_leave0", 4'b1110, 0);
        check("an_digit1", 32'(an16), 32'h0000_000D);
        check("seg_digit1", 32'(seg16), 32'h0000_000D);

        // Toggle in the tick clock: step uses COUNT, then mode is LFSR
        begin
            exp_t e;
            wait_tick16("toggle_tick");
            toggle16 = 1;
            step16   = 1;
            e.name   = "toggle_tick_old_mode";
            e.val    = 16'h1235;
            exp_q.push_back(e);
            @(negedge clock);
            toggle16 = 0;
            step16   = 0;
            @(negedge clock);
            check("toggle_tick_led", 32'(led_lfsr16), 32'h1);
        end
        drain();

        // 8-bit full period from 01
        @(negedge clock);
        toggle8 = 1;
        @(negedge clock);
        toggle8 = 0;
        wait_tick8();
        load8 = 1;
        seed8 = 8'h01;
        @(negedge clock);
        load8 = 0;
        step8 = 1;
        check("lfsr8_loaded", 32'(value8), 32'h01);
        steps = 0;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            wait_tick8();
            @(posedge clock);
            #1;
            steps++;
            if (value8 == 8'h01) found = 1;
        end
        step8 = 0;
        check("lfsr8_period", 32'(steps), 32'd255);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/lfs_scan_counter.md
LFS_SCAN_COUNTER -- requirements
Module: lfs_scan_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the register width; it SHALL be a multiple of 4 in the range 8..32.
REQ-002 SHALL have parameter TAPS, default 16'hB400, meaning the LFSR feedback mask; bit i set puts value[i] in the XOR.
REQ-003 SHALL have parameter DIV_BITS, default 24, meaning the step tick period of 2^DIV_BITS clocks.
REQ-004 SHALL have parameter SCAN_BITS, default 16, meaning the digit dwell of 2^SCAN_BITS clocks.
REQ-005 SHALL define the derived constant DIGITS = WIDTH/4.
REQ-006 SHALL use one clock `clock` and a reset `reset` that is synchronous and active-high.
REQ-007 SHALL have port clock, input, width 1, the single clock.
REQ-008 SHALL have port reset, input, width 1, the synchronous active-high reset.
REQ-009 SHALL have port step, input, width 1, a level enable that advances the value on each tick while high.
REQ-010 SHALL have port toggle, input, width 1, switching mode on each rising edge.
REQ-011 SHALL have port load, input, width 1, loading seed on a tick while high.
REQ-012 SHALL have port seed, input, width WIDTH, the load value.
REQ-013 SHALL have port value, output, width WIDTH, the current register value.
REQ-014 SHALL have port tick, output, width 1, a one-clock pulse every 2^DIV_BITS clocks.
REQ-015 SHALL have port seg, output, width 8, active-low segments {a,b,c,d,e,f,g,dp}.
REQ-016 SHALL have port an, output, width DIGITS, the active-low one-hot digit select.
REQ-017 SHALL have port led_cnt, output, width 1, high when in COUNT mode.
REQ-018 SHALL have port led_lfsr, output, width 1, high when in LFSR mode.

Function
REQ-019 Prescaler SHALL be a free-running DIV_BITS counter; tick SHALL be 1 for the single clock in which the prescaler equals all-ones.
REQ-020 toggle SHALL be edge-detected with one registered previous sample; mode SHALL flip in the clock after a 0->1 transition; a held-high toggle SHALL flip mode once only.
REQ-021 A toggle SHALL NOT alter value.
REQ-022 On tick, the first matching rule SHALL apply: load -> value=seed; else step and COUNT -> value+1 modulo 2^WIDTH; else step and LFSR -> LFSR update; else hold.
REQ-023 LFSR update SHALL be value = {value[WIDTH-2:0], fb}, where fb is the XOR of value bits selected by TAPS.
REQ-024 Lock-up guard: in LFSR mode, a step from value==0 SHALL produce 1.
REQ-025 COUNT wrap SHALL take all-ones to 0 with no flag and no stall.
REQ-026 A tick and a mode flip in the same clock SHALL step using the mode held before the flip.
REQ-027 Outside ticks, value SHALL change only through reset.
REQ-028 led_cnt/led_lfsr SHALL be registered, mutually exclusive, and SHALL follow mode with 1-clock latency.
REQ-029 The scan index SHALL advance every 2^SCAN_BITS clocks and wrap from DIGITS-1 to 0.
REQ-030 an SHALL drive index k low, all others high.
REQ-031 seg SHALL show the hex glyph of value[4k+3:4k] for that k; seg and an SHALL be registered in the same clock so that they never disagree.
REQ-032 Glyphs SHALL be 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001, A=00010001, B=11000001, C=01100011, D=10000101, E=01100001, F=01110001; dp SHALL always be 1.

Reset
REQ-033 When reset is high at a clock edge, the block SHALL set value=0, mode=COUNT, prescaler=0, scan index=0, toggle history=0, tick=0, led_cnt=1, led_lfsr=0, an=~1 (digit 0 low), seg=00000011.
REQ-034 Reset SHALL override load, step and toggle in the same clock, and SHALL apply correctly mid-sequence and mid-scan.

Structure
REQ-035 Package lfs_pkg SHALL hold the mode enum {COUNT, LFSR}, the 16-entry SEG_HEX glyph table and DEFAULT_TAPS_16 = 16'hB400.
REQ-036 Sub-module seg_scan (params DIGITS, SCAN_BITS; inputs: the value bus; outputs: seg, an) SHALL contain the scan counter, nibble mux and glyph lookup.

Verification (WIDTH=16, DIV_BITS=2, SCAN_BITS=1 unless stated)
REQ-037 Count wrap: load FFFE on a tick, then hold step high for 2 ticks -> value FFFF then 0000; led_cnt=1.
REQ-038 LFSR step: load ACE1, pulse toggle, step for 1 tick -> value 59C3; led_lfsr=1; a second toggle pulse leaves value at 59C3.
REQ-039 Lock-up: in LFSR mode, load 0000 then step 1 tick -> 0001; free-run from 0001 -> returns to 0001 after exactly 65535 steps.
REQ-040 Priority: load=1, step=1, seed=1234 on a tick -> value 1234, not 1235; toggle and tick in the same clock -> step uses the old mode.
REQ-041 Display: value 1234 -> an=1110, seg=10011001; after the dwell, an=1101, seg=00001101; WIDTH=32 run -> an cycles through 8 digits.
REQ-042 Reset mid-run: assert reset while in LFSR mode with value 59C3 -> next clock shows all REQ-033 values.
